// File: rtl/imem_pipelined_rom.sv
// rtl/imem_pipelined_rom.sv - synchronous-read instruction memory with configurable-latency pipeline
// Faults are resolved when a request is accepted and travel down the pipeline with it.
module imem_pipelined_rom #(
  parameter int unsigned ALEN        = 32,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ALEN-1:0] req_addr,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_instr,
  output logic [ALEN-1:0] rsp_addr,
  output logic [1:0]      rsp_fault,
  input  logic            prog_we,
  input  logic [ALEN-1:0] prog_addr,
  input  logic [31:0]     prog_data
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ALEN:0] DEPTH_LIMIT = (ALEN+1)'(DEPTH_WORDS);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_pipelined_rom: LATENCY must be in 1..4");
  end

  logic [31:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0] s_valid;
  logic [ALEN-1:0]    s_addr  [LATENCY];
  logic [31:0]        s_instr [LATENCY];
  logic [1:0]         s_fault [LATENCY];

  logic            adv;
  logic            accept;
  logic [ALEN-1:0] req_word;
  logic [ALEN-1:0] prog_word;
  logic            req_misaligned;
  logic            req_oor;
  logic            prog_oor;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] prog_idx;

  // Word-index comparison is widened by one bit so it can never wrap.
  assign req_word       = req_addr >> 2;
  assign prog_word      = prog_addr >> 2;
  assign req_misaligned = (req_addr[1:0] != 2'b00);
  assign req_oor        = ({1'b0, req_word} >= DEPTH_LIMIT);
  assign prog_oor       = ({1'b0, prog_word} >= DEPTH_LIMIT);
  assign req_idx        = req_word[IDX_W-1:0];
  assign prog_idx       = prog_word[IDX_W-1:0];

  assign adv       = !rsp_valid || rsp_ready;
  assign req_ready = adv || flush;
  assign accept    = req_valid && req_ready;

  // Non-blocking write means a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we && !prog_oor) begin
      mem[prog_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        s_valid[i] <= 1'b0;
        s_addr[i]  <= '0;
        s_instr[i] <= NOP_INSTR;
        s_fault[i] <= 2'b00;
      end
    end else if (flush || adv) begin
      s_valid[0] <= accept;
      if (accept) begin
        s_addr[0]  <= req_addr;
        s_fault[0] <= {req_oor, req_misaligned};
        s_instr[0] <= (req_oor || req_misaligned) ? NOP_INSTR : mem[req_idx];
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        s_valid[i] <= flush ? 1'b0 : s_valid[i-1];
        s_addr[i]  <= s_addr[i-1];
        s_instr[i] <= s_instr[i-1];
        s_fault[i] <= s_fault[i-1];
      end
    end
  end

  assign rsp_valid = s_valid[LATENCY-1];
  assign rsp_addr  = s_addr[LATENCY-1];
  assign rsp_instr = s_instr[LATENCY-1];
  assign rsp_fault = s_fault[LATENCY-1];

endmodule

// File: tb/tb_imem_pipelined_rom.sv
// tb/tb_imem_pipelined_rom.sv - bench for imem_pipelined_rom at LATENCY 1, 2 and 4
// Each scenario task runs against one of three instances selected by index k.
module tb_imem_pipelined_rom;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, req_valid, flush, rsp_ready, prog_we;
  logic [2:0]  req_ready, rsp_valid;
  logic [31:0] req_addr  [3];
  logic [31:0] prog_addr [3];
  logic [31:0] prog_data [3];
  logic [31:0] rsp_instr [3];
  logic [31:0] rsp_addr  [3];
  logic [1:0]  rsp_fault [3];

  int lats [3] = '{1, 2, 4};
  logic [31:0] model [3][DEPTH];
  int checks = 0;
  int errors = 0;

  imem_pipelined_rom #(.ALEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1), .NOP_INSTR(NOP)) u_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .flush(flush[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_instr(rsp_instr[0]), .rsp_addr(rsp_addr[0]), .rsp_fault(rsp_fault[0]),
    .prog_we(prog_we[0]), .prog_addr(prog_addr[0]), .prog_data(prog_data[0]));

  imem_pipelined_rom #(.ALEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(2), .NOP_INSTR(NOP)) u_l2 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .flush(flush[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_instr(rsp_instr[1]), .rsp_addr(rsp_addr[1]), .rsp_fault(rsp_fault[1]),
    .prog_we(prog_we[1]), .prog_addr(prog_addr[1]), .prog_data(prog_data[1]));

  imem_pipelined_rom #(.ALEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(4), .NOP_INSTR(NOP)) u_l4 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .flush(flush[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_instr(rsp_instr[2]), .rsp_addr(rsp_addr[2]), .rsp_fault(rsp_fault[2]),
    .prog_we(prog_we[2]), .prog_addr(prog_addr[2]), .prog_data(prog_data[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference answer for a fetch of address a, from the memory image at accept time.
  function automatic rsp_t model_rsp(int k, logic [31:0] a);
    rsp_t r;
    r.addr  = a;
    r.fault = {((a >> 2) >= 32'(DEPTH)), (a[1:0] != 2'b00)};
    if (r.fault != 2'b00) r.instr = NOP;
    else r.instr = model[k][int'(a >> 2)];
    return r;
  endfunction

  task automatic load_mem(int k);
    prog_we[k] = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      prog_addr[k] = 32'(w * 4) | 32'($urandom_range(3));
      prog_data[k] = $urandom;
      model[k][w]  = prog_data[k];
      tick();
    end
    prog_we[k] = 1'b0;
  endtask

  task automatic test_reset(int k);
    rsp_ready[k] = 1'b1;
    req_valid[k] = 1'b1;
    req_addr[k]  = 32'h8;
    tick();
    rst[k] = 1'b0;
    tick();
    tick();
    checks++; if (rsp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_valid L%0d got %0b want 0", lats[k], rsp_valid[k]); end
    checks++; if (rsp_instr[k] !== NOP) begin errors++; $display("FAIL reset_instr L%0d got %h want %h", lats[k], rsp_instr[k], NOP); end
    checks++; if (rsp_addr[k] !== 32'h0) begin errors++; $display("FAIL reset_addr L%0d got %h want 0", lats[k], rsp_addr[k]); end
    checks++; if (rsp_fault[k] !== 2'b00) begin errors++; $display("FAIL reset_fault L%0d got %b want 00", lats[k], rsp_fault[k]); end
    rst[k] = 1'b1;
    req_valid[k] = 1'b0;
    for (int c = 0; c < lats[k] + 2; c++) begin
      tick();
      checks++; if (rsp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_drop L%0d cyc %0d got %0b want 0", lats[k], c, rsp_valid[k]); end
    end
  endtask

  task automatic test_streaming(int k);
    int l = lats[k];
    prog_we[k] = 1'b1;
    for (int w = 0; w < 4; w++) begin
      prog_addr[k] = 32'(w * 4);
      prog_data[k] = 32'hA0 + 32'(w);
      model[k][w]  = prog_data[k];
      tick();
    end
    prog_we[k]   = 1'b0;
    rsp_ready[k] = 1'b1;
    for (int c = 0; c < 4 + l; c++) begin
      int i;
      logic exp_v;
      req_valid[k] = (c < 4);
      req_addr[k]  = 32'(c * 4);
      tick();
      i = c - l + 1;
      exp_v = (i >= 0 && i < 4);
      checks++; if (rsp_valid[k] !== exp_v) begin errors++; $display("FAIL stream_valid L%0d cyc %0d got %0b want %0b", l, c, rsp_valid[k], exp_v); end
      if (exp_v) begin
        checks++; if (rsp_instr[k] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL stream_instr L%0d got %h want %h", l, rsp_instr[k], 32'hA0 + 32'(i)); end
        checks++; if (rsp_addr[k] !== 32'(i * 4)) begin errors++; $display("FAIL stream_addr L%0d got %h want %h", l, rsp_addr[k], 32'(i * 4)); end
        checks++; if (rsp_fault[k] !== 2'b00) begin errors++; $display("FAIL stream_fault L%0d got %b want 00", l, rsp_fault[k]); end
      end
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic test_backpressure(int k);
    rsp_t q[$];
    rsp_t exp_r;
    rsp_t held;
    logic stall;
    int sent = 0;
    for (int c = 0; c < 48; c++) begin
      req_valid[k] = (sent < 24) && ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) req_addr[k] = 32'($urandom_range(DEPTH * 4 + 7));
      else req_addr[k] = 32'($urandom_range(DEPTH - 1) * 4);
      rsp_ready[k] = (c >= 6 && c < 9) ? 1'b0 : ($urandom_range(3) != 0);
      #1;
      checks++; if (req_ready[k] !== (!rsp_valid[k] || rsp_ready[k])) begin errors++; $display("FAIL bp_req_ready L%0d cyc %0d got %0b", lats[k], c, req_ready[k]); end
      if (rsp_valid[k] && rsp_ready[k]) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_extra L%0d addr %h got response want none", lats[k], rsp_addr[k]); end
        else begin
          exp_r = q.pop_front();
          if ({rsp_addr[k], rsp_instr[k], rsp_fault[k]} !== exp_r) begin
            errors++; $display("FAIL bp_rsp L%0d got %h/%h/%b want %h/%h/%b", lats[k], rsp_addr[k], rsp_instr[k], rsp_fault[k], exp_r.addr, exp_r.instr, exp_r.fault);
          end
        end
      end
      if (req_valid[k] && req_ready[k]) begin
        q.push_back(model_rsp(k, req_addr[k]));
        sent++;
      end
      stall = rsp_valid[k] && !rsp_ready[k];
      held  = {rsp_addr[k], rsp_instr[k], rsp_fault[k]};
      tick();
      if (stall) begin
        checks++; if (rsp_valid[k] !== 1'b1 || {rsp_addr[k], rsp_instr[k], rsp_fault[k]} !== held) begin
          errors++; $display("FAIL bp_hold L%0d got %0b %h/%h/%b want 1 %h/%h/%b", lats[k], rsp_valid[k], rsp_addr[k], rsp_instr[k], rsp_fault[k], held.addr, held.instr, held.fault);
        end
      end
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    for (int d = 0; d < lats[k] + 4; d++) begin
      if (rsp_valid[k]) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_drain_extra L%0d addr %h got response want none", lats[k], rsp_addr[k]); end
        else begin
          exp_r = q.pop_front();
          if ({rsp_addr[k], rsp_instr[k], rsp_fault[k]} !== exp_r) begin
            errors++; $display("FAIL bp_drain L%0d got %h/%h/%b want %h/%h/%b", lats[k], rsp_addr[k], rsp_instr[k], rsp_fault[k], exp_r.addr, exp_r.instr, exp_r.fault);
          end
        end
      end
      tick();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL bp_lost L%0d got %0d pending want 0", lats[k], q.size()); end
  endtask

  task automatic test_faults(int k);
    logic [31:0] addrs [4];
    logic [1:0]  want  [4];
    addrs[0] = 32'h6;                 want[0] = 2'b01;
    addrs[1] = 32'(DEPTH * 4);        want[1] = 2'b10;
    addrs[2] = 32'(DEPTH * 4 + 1);    want[2] = 2'b11;
    addrs[3] = 32'($urandom_range(DEPTH - 1) * 4 + $urandom_range(1, 3)); want[3] = 2'b01;
    rsp_ready[k] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid[k] = 1'b1;
      req_addr[k]  = addrs[i];
      tick();
      req_valid[k] = 1'b0;
      repeat (lats[k] - 1) tick();
      checks++; if (rsp_valid[k] !== 1'b1) begin errors++; $display("FAIL fault_valid L%0d addr %h got %0b want 1", lats[k], addrs[i], rsp_valid[k]); end
      checks++; if (rsp_instr[k] !== NOP) begin errors++; $display("FAIL fault_instr L%0d addr %h got %h want %h", lats[k], addrs[i], rsp_instr[k], NOP); end
      checks++; if (rsp_fault[k] !== want[i]) begin errors++; $display("FAIL fault_code L%0d addr %h got %b want %b", lats[k], addrs[i], rsp_fault[k], want[i]); end
      checks++; if (rsp_addr[k] !== addrs[i]) begin errors++; $display("FAIL fault_addr L%0d got %h want %h", lats[k], rsp_addr[k], addrs[i]); end
      tick();
    end
  endtask

  task automatic test_flush(int k);
    int n = 0;
    rsp_ready[k] = 1'b1;
    req_valid[k] = 1'b1;
    req_addr[k]  = 32'h0;
    tick();
    req_addr[k]  = 32'h4;
    tick();
    flush[k]     = 1'b1;
    req_addr[k]  = 32'h40;
    rsp_ready[k] = 1'b0;
    #1;
    checks++; if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL flush_req_ready L%0d got %0b want 1", lats[k], req_ready[k]); end
    tick();
    flush[k]     = 1'b0;
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    for (int c = 0; c < lats[k] + 3; c++) begin
      if (rsp_valid[k]) begin
        n++;
        checks++; if (c != lats[k] - 1) begin errors++; $display("FAIL flush_timing L%0d got cyc %0d want %0d", lats[k], c, lats[k] - 1); end
        checks++; if (rsp_addr[k] !== 32'h40) begin errors++; $display("FAIL flush_addr L%0d got %h want 00000040", lats[k], rsp_addr[k]); end
        checks++; if (rsp_instr[k] !== model[k][16]) begin errors++; $display("FAIL flush_instr L%0d got %h want %h", lats[k], rsp_instr[k], model[k][16]); end
      end
      tick();
    end
    checks++; if (n != 1) begin errors++; $display("FAIL flush_count L%0d got %0d want 1", lats[k], n); end
  endtask

  task automatic test_collision(int k);
    rsp_ready[k] = 1'b1;
    prog_we[k]   = 1'b1;
    prog_addr[k] = 32'h14;
    prog_data[k] = 32'h11;
    tick();
    prog_data[k] = 32'h22;
    req_valid[k] = 1'b1;
    req_addr[k]  = 32'h14;
    tick();
    prog_we[k]   = 1'b0;
    req_valid[k] = 1'b0;
    repeat (lats[k] - 1) tick();
    checks++; if (rsp_valid[k] !== 1'b1 || rsp_instr[k] !== 32'h11) begin errors++; $display("FAIL coll_old L%0d got %0b %h want 1 00000011", lats[k], rsp_valid[k], rsp_instr[k]); end
    tick();
    rsp_ready[k] = 1'b0;
    req_valid[k] = 1'b1;
    tick();
    req_valid[k] = 1'b0;
    repeat (lats[k] - 1) tick();
    checks++; if (rsp_valid[k] !== 1'b1 || rsp_instr[k] !== 32'h22) begin errors++; $display("FAIL coll_new L%0d got %0b %h want 1 00000022", lats[k], rsp_valid[k], rsp_instr[k]); end
    prog_we[k]   = 1'b1;
    prog_data[k] = 32'h33;
    tick();
    prog_we[k]   = 1'b0;
    checks++; if (rsp_valid[k] !== 1'b1 || rsp_instr[k] !== 32'h22) begin errors++; $display("FAIL coll_stall_write L%0d got %0b %h want 1 00000022", lats[k], rsp_valid[k], rsp_instr[k]); end
    rsp_ready[k] = 1'b1;
    tick();
    checks++; if (rsp_valid[k] !== 1'b0) begin errors++; $display("FAIL coll_consumed L%0d got %0b want 0", lats[k], rsp_valid[k]); end
    model[k][5] = 32'h33;
  endtask

  initial begin
    rst = 3'b000; req_valid = '0; flush = '0; rsp_ready = '0; prog_we = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = '0; prog_addr[k] = '0; prog_data[k] = '0;
    end
    tick();
    tick();
    rst = 3'b111;
    for (int k = 0; k < 3; k++) begin
      load_mem(k);
      test_reset(k);
      test_streaming(k);
      test_backpressure(k);
      test_faults(k);
      test_flush(k);
      test_collision(k);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
